// File: rtl/sdiv_fsm.sv
// -----------------------------------------------------------------------------
// sdiv_fsm
//
// Sequential signed divider. A 2*DATAWIDTH-bit two's-complement dividend is
// divided by a DATAWIDTH-bit two's-complement divisor with restoring
// division, one quotient bit per clock. The quotient is truncated toward
// zero, and the remainder takes the sign of the dividend. It is the
// companion of the sequential Booth multiplier in the PE datapath, and it
// rescales and normalises partial sums.
//
// Latency: a request accepted in IDLE produces done DATAWIDTH+3 cycles later,
// or 2 cycles later when the divisor is zero or the quotient obviously
// cannot fit (precheck).
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   en           in   1       start request, sampled only in IDLE
//   dividend     in   2*W     signed dividend, captured on the accepting edge
//   divisor      in   W       signed divisor, captured on the accepting edge
//   busy         out  1       high in every state except IDLE
//   done         out  1       one-cycle pulse, results valid from this cycle
//   quotient     out  W       signed quotient, held until the next done
//   remainder    out  W       signed remainder, held until the next done
//   div_by_zero  out  1       divisor was zero, held until the next done
//   overflow     out  1       quotient not representable in W bits
// -----------------------------------------------------------------------------
module sdiv_fsm #(
    parameter int DATAWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2*DATAWIDTH-1:0]   dividend,
    input  logic [DATAWIDTH-1:0]     divisor,
    output logic                     busy,
    output logic                     done,
    output logic [DATAWIDTH-1:0]     quotient,
    output logic [DATAWIDTH-1:0]     remainder,
    output logic                     div_by_zero,
    output logic                     overflow
);

    localparam int W     = DATAWIDTH;
    localparam int CNT_W = $clog2(W + 1);

    // Index of the final ITER cycle.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    // Magnitude of the most negative W-bit value (2^(W-1)). This is the
    // largest quotient magnitude allowed when the quotient is negative.
    localparam logic [W-1:0] NEG_LIMIT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // Operands and their signs, captured on the accepting edge.
    logic [2*W-1:0]   dvd_lat;
    logic [W-1:0]     dvs_lat;
    logic             dvd_neg;
    logic             dvs_neg;

    // Working registers for the restoring loop. The partial remainder is
    // conceptually W+1 bits wide. After every step it is strictly below
    // |divisor|, which is at most 2^(W-1), so its stored value always fits
    // in W bits. The extra bit appears only in the shifted trial value.
    logic [W-1:0]     dvs_mag;
    logic [W-1:0]     part_rem;
    logic [W-1:0]     part_quo;
    logic [CNT_W-1:0] iter_cnt;

    // ------------------------------------------------------------------
    // PREP: magnitudes and prechecks, formed from the latched operands
    // ------------------------------------------------------------------
    logic [2*W-1:0] dvd_mag;
    logic [W-1:0]   dvs_abs;
    logic           pre_zero;
    logic           pre_ovf;

    // Negation in the operand's own width maps the most negative value onto
    // itself. Read as unsigned, that is exactly its magnitude, 2^(n-1).
    assign dvd_mag  = dvd_neg ? -dvd_lat : dvd_lat;
    assign dvs_abs  = dvs_neg ? -dvs_lat : dvs_lat;
    assign pre_zero = (dvs_lat == '0);
    // The upper half of |dividend| must be below |divisor|. Otherwise the
    // unsigned quotient needs more than W bits.
    assign pre_ovf  = (dvd_mag[2*W-1:W] >= dvs_abs);

    // ------------------------------------------------------------------
    // ITER: one restoring step
    // ------------------------------------------------------------------
    logic [W:0]   shift_rem;
    logic [W+1:0] trial;
    logic         trial_ok;

    assign shift_rem = {part_rem, part_quo[W-1]};
    // One guard bit, so the sign of the trial subtraction is explicit.
    assign trial     = {1'b0, shift_rem} - {2'b00, dvs_mag};
    assign trial_ok  = ~trial[W+1];

    // ------------------------------------------------------------------
    // FIX: apply signs and check the final range
    // ------------------------------------------------------------------
    logic         quo_neg;
    logic         fix_ovf;
    logic [W-1:0] fix_quo;
    logic [W-1:0] fix_rem;

    assign quo_neg = dvd_neg ^ dvs_neg;
    // A positive quotient may reach 2^(W-1)-1, so the MSB must be clear.
    // A negative quotient may reach -2^(W-1).
    assign fix_ovf = quo_neg ? (part_quo > NEG_LIMIT) : part_quo[W-1];
    assign fix_quo = quo_neg ? -part_quo : part_quo;
    // The remainder follows the dividend's sign. Negating zero gives zero.
    assign fix_rem = dvd_neg ? -part_rem : part_rem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments, so every
    // flop samples the pre-edge values. Blocking assignments here would
    // make the result depend on statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous. It is sampled only on a rising clock
        // edge, and it takes priority over any start request on that edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first. A path that
    // leaves a variable unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (en) begin
                    state_nx = PREP;
                end
            end
            PREP: begin
                if (pre_zero || pre_ovf) begin
                    state_nx = DONE;
                end else begin
                    state_nx = ITER;
                end
            end
            ITER: begin
                if (iter_cnt == LAST_ITER) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_lat     <= '0;
            dvs_lat     <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvs_mag     <= '0;
            part_rem    <= '0;
            part_quo    <= '0;
            iter_cnt    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        dvd_lat <= dividend;
                        dvs_lat <= divisor;
                        dvd_neg <= dividend[2*W-1];
                        dvs_neg <= divisor[W-1];
                    end
                end
                PREP: begin
                    dvs_mag  <= dvs_abs;
                    part_rem <= dvd_mag[2*W-1:W];
                    part_quo <= dvd_mag[W-1:0];
                    iter_cnt <= '0;
                    // Results change only on the edge that enters DONE.
                    // From PREP that happens only on the error paths.
                    if (pre_zero) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else if (pre_ovf) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end
                end
                ITER: begin
                    // Shift {R,Q} left. Keep R-|divisor| when it is not
                    // negative, and shift the matching quotient bit into Q.
                    part_rem <= trial_ok ? trial[W-1:0] : shift_rem[W-1:0];
                    part_quo <= {part_quo[W-2:0], trial_ok};
                    iter_cnt <= iter_cnt + 1'b1;
                end
                FIX: begin
                    div_by_zero <= 1'b0;
                    overflow    <= fix_ovf;
                    if (fix_ovf) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= fix_quo;
                        remainder <= fix_rem;
                    end
                end
                default: begin
                    // DONE: results already registered, nothing to update.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_fsm.sv
// -----------------------------------------------------------------------------
// tb_sdiv_fsm
//
// Directed testbench for sdiv_fsm with DATAWIDTH=8. Expected values are
// worked out by hand from the operands. Outputs are sampled on the falling
// edge. Inputs change on the falling edge as well, so they are stable at
// every rising edge.
// -----------------------------------------------------------------------------
module tb_sdiv_fsm;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sdiv_fsm #(.DATAWIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen so far. Used to measure the spacing of done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one request and waits, with a bound, for done. lat is the
    // number of cycles from the accepting edge to the done cycle (-1 on
    // timeout). bcnt is the number of sampled cycles in which busy was high.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output int bcnt);
        @(negedge clk);
        en       = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            en = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_div(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf, input int exp_lat);
        int lat;
        int bcnt;
        run_op(a, b, lat, bcnt);
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".busy_cycles"}, bcnt, exp_lat);
        check({name, ".quotient"}, 32'(quotient), 32'(exp_q));
        check({name, ".remainder"}, 32'(remainder), 32'(exp_r));
        check({name, ".div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
        check({name, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        // The next cycle is back in IDLE. done has dropped, and the results hold.
        @(negedge clk);
        check({name, ".done_pulse"}, 32'({busy, done}), 32'h0);
        check({name, ".hold"}, 32'({quotient, remainder}), 32'({exp_q, exp_r}));
    endtask

    initial begin
        int t1;
        int t2;
        bit seen_done;

        rst      = 1'b1;
        en       = 1'b1;   // rst has priority over en
        dividend = 16'd100;
        divisor  = 8'd7;
        repeat (2) @(negedge clk);
        check("reset.outputs",
              32'({busy, done, div_by_zero, overflow, quotient, remainder}), 32'h0);
        rst = 1'b0;
        en  = 1'b0;

        // Basic case, then the four sign combinations of 100 and 7.
        do_div("pos_pos", 16'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0, 11);
        do_div("neg_pos", 16'hFF9C, 8'd7,  8'hF2,  8'hFE, 1'b0, 1'b0, 11);
        do_div("pos_neg", 16'd100, 8'hF9,  8'hF2,  8'h02, 1'b0, 1'b0, 11);
        do_div("neg_neg", 16'hFF9C, 8'hF9, 8'h0E,  8'hFE, 1'b0, 1'b0, 11);

        // Error and range boundaries.
        do_div("div_zero",    16'h1234, 8'd0,  8'h00, 8'h00, 1'b1, 1'b0, 2);
        do_div("pre_ovf",     16'h4000, 8'd1,  8'h00, 8'h00, 1'b0, 1'b1, 2);
        do_div("fix_ovf",     16'sd128, 8'd1,  8'h00, 8'h00, 1'b0, 1'b1, 11);
        do_div("min_quo",     16'hFF80, 8'd1,  8'h80, 8'h00, 1'b0, 1'b0, 11);
        do_div("pre_ovf_min", 16'h8000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 2);

        // en held high: back-to-back divisions with a disturbance while busy.
        @(negedge clk);
        en       = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
        @(posedge clk);
        @(negedge clk);
        check("b2b.busy_after_accept", 32'(busy), 32'h1);
        dividend = 16'd77;
        divisor  = 8'd3;
        repeat (3) @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd5;
        t1 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                t1 = cyc;
                break;
            end
        end
        check("b2b.first_done_seen", 32'(t1 >= 0), 32'h1);
        check("b2b.first_quotient", 32'({quotient, remainder}), 32'h0A00);
        t2 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                t2 = cyc;
                break;
            end
        end
        en = 1'b0;
        check("b2b.spacing", t2 - t1, 12);
        check("b2b.second_quotient", 32'({quotient, remainder}), 32'h0A00);

        // Reset during the 4th ITER cycle aborts the division.
        @(negedge clk);
        en       = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd7;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;                 // cycle 1: PREP
        repeat (4) @(negedge clk); // cycle 5: 4th ITER cycle
        check("abort.busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.outputs_cleared",
              32'({busy, done, div_by_zero, overflow, quotient, remainder}), 32'h0);
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort.no_done", 32'(seen_done), 32'h0);
        do_div("after_abort", 16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
